dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Round-robin arbiter and sequencer that shares the two ports of the 64x8 dual-port RAM (`dpram`) among NREQ requesters. Each cycle it grants up to two requests, one per RAM port, and drives the RAM's active-low write strobes, addresses and write data from registers. It blocks same-address hazards between the two ports and returns read data to the originating requester with a fixed latency. It sits between the requester fabric and the `dpram` instance.

## Interface

**Parameters**
- NREQ, 4, number of requesters (2..8)
- AW, 6, address width (matches RAM depth 64)
- DW, 8, data width

**Ports** (name, direction, width, meaning)
- clk, in, 1, clock; all logic on the rising edge
- rst, in, 1, synchronous, active-high reset
- req, in, NREQ, request valid per requester; held until granted
- req_we, in, NREQ, 1 = write, 0 = read
- req_addr, in, NREQ*AW, request address; requester i uses slice [i*AW +: AW]
- req_wdata, in, NREQ*DW, write data; requester i uses slice [i*DW +: DW]
- gnt, out, NREQ, combinational grant; a request is consumed at the edge where req[i]&gnt[i]
- rvalid, out, NREQ, registered one-cycle read-return strobe
- rdata, out, NREQ*DW, registered read data; slice i is valid when rvalid[i] is high
- mem_en, out, 1, to RAM en
- mem_wr0, mem_wr1, out, 1 each, to RAM wr0/wr1; 0 = write, 1 = read
- mem_add0, mem_add1, out, AW each, to RAM add0/add1
- mem_data0_in, mem_data1_in, out, DW each, to RAM data0_in/data1_in
- mem_data0_out, mem_data1_out, in, DW each, from RAM data0_out/data1_out

## Operation

- Rotating pointer ptr (0..NREQ-1) sets scan order: ptr, ptr+1, … mod NREQ.
- Grant selection (combinational, cycle t):
  - The first requesting index in scan order is the port-0 candidate.
  - Scanning continues for a port-1 candidate. Skip any index whose address equals the port-0 address when either request is a write.
  - The first non-conflicting index found is granted port 1.
  - Two reads to the same address are both granted.
- Up to two gnt bits are high at once; gnt is never high for a requester with req low.
- On a consuming edge (E):
  - mem_addX, mem_wrX = ~req_we and mem_dataX_in are registered from the granted requester.
  - Requester id and read flag enter a 2-stage return pipe per port.
- Idle port: mem_wrX = 1, and address and data hold their previous value. RAM reads on an idle port are discarded (no rvalid).
- Read return:
  - Port X data is captured from mem_dataX_out two edges after E.
  - It is presented on rdata[id] with rvalid[id] = 1 for exactly one cycle.
- Pointer update: after any grant, ptr = (highest-scan-order granted index + 1) mod NREQ. ptr is unchanged when there is no grant.
- mem_en is 0 during reset and 1 otherwise, so the RAM clears its data outputs at reset.
- Ordering: a write consumed at E updates the RAM at E+1. A read to the same address consumed at E+1 or later returns the new data.

## Timing

- Reset values (edge with rst=1):
  - ptr=0, rvalid=0, rdata=0, mem_en=0, mem_wr0=mem_wr1=1, mem_add*=0, mem_data*_in=0, return pipes empty.
- While rst=1, gnt=0 combinationally. Reset mid-operation drops all in-flight reads, with no rvalid afterwards.
- Read latency: granted in cycle t gives rvalid in cycle t+3. Throughput is up to 2 accesses per cycle.
- Write: granted in cycle t gives mem_wrX=0 during t+1, and the RAM is written at the end of t+1. No acknowledgement beyond gnt.
- Back-to-back grants to the same requester in consecutive cycles are allowed. Return order per requester matches grant order.
- Port-0 and port-1 returns in the same cycle target different requesters. Both rvalid bits may be high together.
- The first cycle after reset release has mem_en=0 still registered. Grants are permitted in that cycle; the RAM sees en=1 from the following cycle, which is when the first granted access is driven.

## Test plan

- Reset, then single write then read: req0 writes 0xA5 to addr 0x10, then req0 reads 0x10. Required: gnt0 in each request cycle, mem_wr0=0 for one cycle, rvalid[0] exactly 3 cycles after the read grant, rdata[0]=0xA5.
- Dual grant: req1 reads 0x05 and req2 reads 0x06 in the same cycle. Required: both granted, port 0 to req1 and port 1 to req2, both rvalid high together 3 cycles later with the correct data.
- Collision: req0 writes 0x3F and req1 reads 0x3F in the same cycle, with ptr=0. Required: only gnt0. req1 is granted the next cycle and returns the newly written value.
- Fairness: all 4 requesters hold reads continuously for 8 cycles. Required: grant pairs (0,1), (2,3), (0,1), (2,3)…, and no requester is starved for more than 2 cycles.
- Same-address reads: req2 and req3 both read 0x20. Required: both granted in the same cycle, both return identical data.
- Reset mid-flight: a read is granted, then rst is asserted on the next cycle. Required: no rvalid, mem_en=0, gnt=0 while reset, ptr=0 after reset.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter
//
// Shares the two ports of a 64x8 dual-port RAM among NREQ requesters using a
// rotating-priority scan. Each cycle up to two requests are granted, one per
// RAM port. Address, write strobe and write data toward the RAM are
// registered. Reads return on rdata/rvalid of the originating requester three
// cycles after the grant.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req                  per-requester request valid (held until granted)
//   req_we               per-requester write flag (1 = write, 0 = read)
//   req_addr             packed request addresses, slice i = [i*AW +: AW]
//   req_wdata            packed write data, slice i = [i*DW +: DW]
//   gnt                  combinational grant; request consumed when req&gnt
//   rvalid               registered one-cycle read-return strobe per requester
//   rdata                registered read data, slice i valid with rvalid[i]
//   mem_en               RAM enable (low during reset)
//   mem_wr0, mem_wr1     RAM write strobes, active low
//   mem_add0, mem_add1   RAM addresses
//   mem_data0_in/1_in    RAM write data
//   mem_data0_out/1_out  RAM read data
module dpram_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [NREQ*DW-1:0]   rdata,
  output logic                 mem_en,
  output logic                 mem_wr0,
  output logic                 mem_wr1,
  output logic [AW-1:0]        mem_add0,
  output logic [AW-1:0]        mem_add1,
  output logic [DW-1:0]        mem_data0_in,
  output logic [DW-1:0]        mem_data1_in,
  input  logic [DW-1:0]        mem_data0_out,
  input  logic [DW-1:0]        mem_data1_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Unpacked views of the packed request buses
  logic [NREQ-1:0][AW-1:0] addr_arr;
  logic [NREQ-1:0][DW-1:0] wdata_arr;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  // RAM read data, indexed by port
  logic [1:0][DW-1:0] mem_dout;
  assign mem_dout = {mem_data1_out, mem_data0_out};

  // Registered state
  logic [IW-1:0]           ptr_reg;
  logic [IW-1:0]           ptr_next;
  logic                    mem_en_reg;
  logic [1:0]              mem_wr_reg;
  logic [1:0][AW-1:0]      mem_add_reg;
  logic [1:0][DW-1:0]      mem_din_reg;
  // Two-stage return pipe per port: stage 1 tracks the cycle the RAM sees the
  // address, stage 2 the cycle its output is valid.
  logic [1:0]              pv1_reg;
  logic [1:0]              pv2_reg;
  logic [1:0][IW-1:0]      pid1_reg;
  logic [1:0][IW-1:0]      pid2_reg;
  logic [NREQ-1:0]         rvalid_reg;
  logic [NREQ-1:0][DW-1:0] rdata_reg;

  // Grant selection results
  logic [1:0]              port_found;
  logic [1:0][IW-1:0]      port_idx;
  logic [IW-1:0]           scan_idx;
  logic [IW-1:0]           last_idx;

  // Scan from ptr_reg: first requester takes port 0, the next one that does
  // not collide with it takes port 1. A collision is a same-address pair
  // where at least one side writes; two reads of one address are harmless.
  always_comb begin
    port_found = '0;
    port_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IW'((int'(ptr_reg) + k) % NREQ);
      if (req[scan_idx]) begin
        if (!port_found[0]) begin
          port_found[0] = 1'b1;
          port_idx[0]   = scan_idx;
        end else if (!port_found[1] &&
                     !((addr_arr[scan_idx] == addr_arr[port_idx[0]]) &&
                       (req_we[scan_idx] || req_we[port_idx[0]]))) begin
          port_found[1] = 1'b1;
          port_idx[1]   = scan_idx;
        end
      end
    end
    if (rst) begin
      port_found = '0;
    end
  end

  always_comb begin
    gnt = '0;
    for (int p = 0; p < 2; p++) begin
      if (port_found[p]) begin
        gnt[port_idx[p]] = 1'b1;
      end
    end
  end

  // Port 1 is always later in scan order than port 0, so it decides the
  // pointer whenever it is granted.
  always_comb begin
    last_idx = port_found[1] ? port_idx[1] : port_idx[0];
    ptr_next = ptr_reg;
    if (port_found[0]) begin
      ptr_next = (int'(last_idx) == NREQ - 1) ? '0 : last_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      mem_en_reg  <= 1'b0;
      mem_wr_reg  <= 2'b11;
      mem_add_reg <= '0;
      mem_din_reg <= '0;
      pv1_reg     <= '0;
      pv2_reg     <= '0;
      pid1_reg    <= '0;
      pid2_reg    <= '0;
      rvalid_reg  <= '0;
      rdata_reg   <= '0;
    end else begin
      ptr_reg    <= ptr_next;
      mem_en_reg <= 1'b1;
      rvalid_reg <= '0;
      for (int p = 0; p < 2; p++) begin
        if (port_found[p]) begin
          mem_add_reg[p] <= addr_arr[port_idx[p]];
          mem_wr_reg[p]  <= ~req_we[port_idx[p]];
          mem_din_reg[p] <= wdata_arr[port_idx[p]];
        end else begin
          // Idle port reads whatever address it last held; no return is
          // scheduled for it.
          mem_wr_reg[p] <= 1'b1;
        end
        pv1_reg[p]  <= port_found[p] & ~req_we[port_idx[p]];
        pid1_reg[p] <= port_idx[p];
        pv2_reg[p]  <= pv1_reg[p];
        pid2_reg[p] <= pid1_reg[p];
        // Both ports never return to the same requester in one cycle, since
        // they were granted to different requesters in the same cycle.
        if (pv2_reg[p]) begin
          rvalid_reg[pid2_reg[p]] <= 1'b1;
          rdata_reg[pid2_reg[p]]  <= mem_dout[p];
        end
      end
    end
  end

  assign rvalid       = rvalid_reg;
  assign rdata        = rdata_reg;
  assign mem_en       = mem_en_reg;
  assign mem_wr0      = mem_wr_reg[0];
  assign mem_wr1      = mem_wr_reg[1];
  assign mem_add0     = mem_add_reg[0];
  assign mem_add1     = mem_add_reg[1];
  assign mem_data0_in = mem_din_reg[0];
  assign mem_data1_in = mem_din_reg[1];

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed testbench for dpram_arbiter with a behavioural 64x8 dual-port RAM.
// RAM contents are loaded with addr*3+1 while rst is high.
module tb_dpram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [NREQ*DW-1:0]   rdata;
  logic                 mem_en;
  logic                 mem_wr0;
  logic                 mem_wr1;
  logic [AW-1:0]        mem_add0;
  logic [AW-1:0]        mem_add1;
  logic [DW-1:0]        mem_data0_in;
  logic [DW-1:0]        mem_data1_in;
  logic [DW-1:0]        mem_data0_out;
  logic [DW-1:0]        mem_data1_out;

  int n_checks = 0;
  int n_errors = 0;

  dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_en        (mem_en),
    .mem_wr0       (mem_wr0),
    .mem_wr1       (mem_wr1),
    .mem_add0      (mem_add0),
    .mem_add1      (mem_add1),
    .mem_data0_in  (mem_data0_in),
    .mem_data1_in  (mem_data1_in),
    .mem_data0_out (mem_data0_out),
    .mem_data1_out (mem_data1_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, active-low write, outputs cleared when
  // en is low.
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'(i * 3 + 1);
    end
    if (!mem_en) begin
      mem_data0_out <= '0;
      mem_data1_out <= '0;
    end else begin
      if (!mem_wr0) ram[mem_add0] <= mem_data0_in;
      else          mem_data0_out <= ram[mem_add0];
      if (!mem_wr1) ram[mem_add1] <= mem_data1_in;
      else          mem_data1_out <= ram[mem_add1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req    = '0;
    req_we = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) next_cycle();

    // Reset state; requests present but gnt must stay low
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
    #2;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_wr0", mem_wr0, 1'b1);
    check("rst_wr1", mem_wr1, 1'b1);
    check("rst_add0", mem_add0, 0);
    check("rst_add1", mem_add1, 0);
    check("rst_din0", mem_data0_in, 0);
    check("rst_rvalid", rvalid, 4'b0000);
    check("rst_rdata", rdata, 0);
    clear_req();

    // Single write then read by requester 0
    next_cycle();
    rst = 1'b0;
    set_req(0, 1'b1, 6'h10, 8'hA5);
    #2;
    check("t1_wr_gnt", gnt, 4'b0001);
    check("t1_first_en", mem_en, 1'b0);
    next_cycle();
    clear_req();
    check("t1_wr0_low", mem_wr0, 1'b0);
    check("t1_add0", mem_add0, 6'h10);
    check("t1_din0", mem_data0_in, 8'hA5);
    check("t1_wr1_idle", mem_wr1, 1'b1);
    check("t1_en", mem_en, 1'b1);
    set_req(0, 1'b0, 6'h10, 8'h00);
    #2;
    check("t1_rd_gnt", gnt, 4'b0001);
    next_cycle();
    clear_req();
    check("t1_wr0_one_cycle", mem_wr0, 1'b1);
    check("t1_rvalid_c2", rvalid, 4'b0000);
    next_cycle();
    check("t1_rvalid_c3", rvalid, 4'b0000);
    next_cycle();
    check("t1_rvalid", rvalid, 4'b0001);
    check("t1_rdata", rd(0), 8'hA5);
    next_cycle();
    check("t1_rvalid_off", rvalid, 4'b0000);

    // Dual grant: req1 reads 0x05, req2 reads 0x06 (ptr = 1)
    set_req(1, 1'b0, 6'h05, 8'h00);
    set_req(2, 1'b0, 6'h06, 8'h00);
    #2;
    check("t2_gnt", gnt, 4'b0110);
    next_cycle();
    clear_req();
    check("t2_add0", mem_add0, 6'h05);
    check("t2_add1", mem_add1, 6'h06);
    check("t2_wr0", mem_wr0, 1'b1);
    check("t2_wr1", mem_wr1, 1'b1);
    next_cycle();
    check("t2_rvalid_early", rvalid, 4'b0000);
    next_cycle();
    check("t2_rvalid", rvalid, 4'b0110);
    check("t2_rdata1", rd(1), 8'h10);
    check("t2_rdata2", rd(2), 8'h13);

    // Bring ptr from 3 to 0 with a lone write by req3
    set_req(3, 1'b1, 6'h30, 8'h77);
    #2;
    check("t3_pre_gnt", gnt, 4'b1000);
    next_cycle();
    clear_req();

    // Collision: req0 writes 0x3F, req1 reads 0x3F, ptr = 0
    set_req(0, 1'b1, 6'h3F, 8'hC3);
    set_req(1, 1'b0, 6'h3F, 8'h00);
    #2;
    check("t3_gnt_collide", gnt, 4'b0001);
    next_cycle();
    check("t3_wr0", mem_wr0, 1'b0);
    check("t3_add0", mem_add0, 6'h3F);
    req[0] = 1'b0;
    #2;
    check("t3_gnt_retry", gnt, 4'b0010);
    next_cycle();
    clear_req();
    check("t3_rvalid_early", rvalid, 4'b0000);
    next_cycle();
    next_cycle();
    check("t3_rvalid", rvalid, 4'b0010);
    check("t3_rdata1", rd(1), 8'hC3);

    // Bring ptr from 2 to 0 with a lone write by req3
    set_req(3, 1'b1, 6'h31, 8'h55);
    #2;
    check("t4_pre_gnt", gnt, 4'b1000);
    next_cycle();
    clear_req();

    // Fairness: all four read continuously for 8 cycles
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("t4_gnt_%0d", k), gnt, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      if (k >= 3) begin
        check($sformatf("t4_rvalid_%0d", k), rvalid,
              ((k - 3) % 2 == 0) ? 4'b0011 : 4'b1100);
      end
      next_cycle();
    end
    clear_req();
    for (int k = 8; k < 11; k++) begin
      check($sformatf("t4_rvalid_%0d", k), rvalid,
            ((k - 3) % 2 == 0) ? 4'b0011 : 4'b1100);
      if ((k - 3) % 2 == 0) check($sformatf("t4_rdata0_%0d", k), rd(0), 8'h01);
      else                  check($sformatf("t4_rdata3_%0d", k), rd(3), 8'h0A);
      next_cycle();
    end
    check("t4_rvalid_drained", rvalid, 4'b0000);

    // Same-address reads by req2 and req3 (ptr = 0)
    set_req(2, 1'b0, 6'h20, 8'h00);
    set_req(3, 1'b0, 6'h20, 8'h00);
    #2;
    check("t5_gnt", gnt, 4'b1100);
    next_cycle();
    clear_req();
    check("t5_add0", mem_add0, 6'h20);
    check("t5_add1", mem_add1, 6'h20);
    next_cycle();
    next_cycle();
    check("t5_rvalid", rvalid, 4'b1100);
    check("t5_rdata2", rd(2), 8'h61);
    check("t5_rdata3", rd(3), 8'h61);

    // Reset mid-flight
    set_req(0, 1'b0, 6'h01, 8'h00);
    #2;
    check("t6_gnt", gnt, 4'b0001);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
    #2;
    check("t6_gnt_in_rst", gnt, 4'b0000);
    next_cycle();
    check("t6_en_rst", mem_en, 1'b0);
    check("t6_rvalid_rst", rvalid, 4'b0000);
    #2;
    check("t6_gnt_in_rst2", gnt, 4'b0000);
    next_cycle();
    rst = 1'b0;
    check("t6_rvalid_rel", rvalid, 4'b0000);
    check("t6_en_rel", mem_en, 1'b0);
    #2;
    check("t6_gnt_ptr0", gnt, 4'b0011);
    next_cycle();
    clear_req();
    check("t6_rvalid_h4", rvalid, 4'b0000);
    check("t6_en", mem_en, 1'b1);
    check("t6_add1", mem_add1, 6'h01);
    next_cycle();
    check("t6_rvalid_h5", rvalid, 4'b0000);
    next_cycle();
    check("t6_rvalid", rvalid, 4'b0011);
    check("t6_rdata0", rd(0), 8'h01);
    check("t6_rdata1", rd(1), 8'h04);
    next_cycle();
    check("t6_rvalid_off", rvalid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
